// File: rtl/traffic_sel_if.sv
// rtl/traffic_sel_if.sv - per-frame vehicle count stream into the traffic select scheduler
// The producer owns valid and the counts; the scheduler owns ready.
interface traffic_sel_if #(
  parameter int CNT_W = 8
);
  logic             cnt_valid;
  logic             cnt_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (output cnt_valid, output cnt_a, output cnt_b, input  cnt_ready);
  modport slave  (input  cnt_valid, input  cnt_a, input  cnt_b, output cnt_ready);
endinterface

// File: rtl/traffic_sel_scheduler.sv
// rtl/traffic_sel_scheduler.sv - windowed flow classifier with hysteresis, commits traffic_sel at cycle boundaries
// Optional emergency override is enabled with TRAFFIC_SCHED_EMERG_EN.
module traffic_sel_scheduler #(
  parameter int CNT_W       = 8,
  parameter int ACC_W       = 12,
  parameter int WIN_FRAMES  = 16,
  parameter int HYST        = 2,
  parameter int RATIO_SHIFT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  traffic_sel_if.slave cnt_if,
  input  logic       cycle_done_i,
`ifdef TRAFFIC_SCHED_EMERG_EN
  input  logic       emerg_req_i,
  input  logic [1:0] emerg_sel_i,
`endif
  output logic [1:0] traffic_sel_o,
  output logic       sel_update_o,
  output logic       pend_valid_o
);

  localparam int FC_W = $clog2(WIN_FRAMES + 1);
  localparam int AG_W = $clog2(HYST + 1);
  localparam logic [FC_W-1:0] WIN_V  = FC_W'(WIN_FRAMES);
  localparam logic [AG_W-1:0] HYST_V = AG_W'(HYST);

  typedef enum logic {ACCUM, DECIDE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [FC_W-1:0]  frame_q, frame_d;
  logic [1:0]       last_cand_q, last_cand_d;
  logic [AG_W-1:0]  agree_q, agree_d;
  logic [1:0]       sel_q, sel_d, pend_sel_q, pend_sel_d;
  logic             upd_q, upd_d, pend_valid_q, pend_valid_d;
  logic             live_q;

  logic             xfer;
  logic [1:0]       cand;
  logic [ACC_W:0]   a_ext, b_ext, thr_a, thr_b;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [CNT_W-1:0] cnt);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, cnt};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Ready only after the first clock out of reset, and never during an override.
`ifdef TRAFFIC_SCHED_EMERG_EN
  assign cnt_if.cnt_ready = live_q && (state_q == ACCUM) && !emerg_req_i;
`else
  assign cnt_if.cnt_ready = live_q && (state_q == ACCUM);
`endif
  assign xfer = cnt_if.cnt_valid && cnt_if.cnt_ready;

  // One extra bit keeps y + (y >> RATIO_SHIFT) from overflowing.
  assign a_ext = {1'b0, acc_a_q};
  assign b_ext = {1'b0, acc_b_q};
  assign thr_a = a_ext + (a_ext >> RATIO_SHIFT);
  assign thr_b = b_ext + (b_ext >> RATIO_SHIFT);
  assign cand  = (a_ext > thr_b) ? 2'd2 : ((b_ext > thr_a) ? 2'd1 : 2'd0);

  always_comb begin
    state_d      = state_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    frame_d      = frame_q;
    last_cand_d  = last_cand_q;
    agree_d      = agree_q;
    sel_d        = sel_q;
    pend_sel_d   = pend_sel_q;
    pend_valid_d = pend_valid_q;
    upd_d        = 1'b0;

    // Commit first so a same-cycle decision is judged against the new selection.
    if (cycle_done_i && pend_valid_q) begin
      sel_d        = pend_sel_q;
      upd_d        = 1'b1;
      pend_valid_d = 1'b0;
    end

    case (state_q)
      ACCUM: begin
        if (xfer) begin
          acc_a_d = sat_add(acc_a_q, cnt_if.cnt_a);
          acc_b_d = sat_add(acc_b_q, cnt_if.cnt_b);
          frame_d = frame_q + 1'b1;
          if (frame_d == WIN_V) state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (cand == last_cand_q) begin
          agree_d = (agree_q == HYST_V) ? agree_q : agree_q + 1'b1;
        end else begin
          last_cand_d = cand;
          agree_d     = AG_W'(1);
        end
        if (agree_d == HYST_V) begin
          if (cand != sel_d) begin
            pend_sel_d   = cand;
            pend_valid_d = 1'b1;
          end else begin
            pend_valid_d = 1'b0;
          end
        end
        acc_a_d = '0;
        acc_b_d = '0;
        frame_d = '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

`ifdef TRAFFIC_SCHED_EMERG_EN
    if (emerg_req_i) begin
      sel_d        = (emerg_sel_i == 2'd3) ? 2'd0 : emerg_sel_i;
      upd_d        = (sel_d != sel_q);
      acc_a_d      = '0;
      acc_b_d      = '0;
      frame_d      = '0;
      agree_d      = '0;
      pend_valid_d = 1'b0;
      state_d      = ACCUM;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ACCUM;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      frame_q      <= '0;
      last_cand_q  <= 2'd0;
      agree_q      <= '0;
      sel_q        <= 2'd0;
      pend_sel_q   <= 2'd0;
      pend_valid_q <= 1'b0;
      upd_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      frame_q      <= frame_d;
      last_cand_q  <= last_cand_d;
      agree_q      <= agree_d;
      sel_q        <= sel_d;
      pend_sel_q   <= pend_sel_d;
      pend_valid_q <= pend_valid_d;
      upd_q        <= upd_d;
      live_q       <= 1'b1;
    end
  end

  assign traffic_sel_o = sel_q;
  assign sel_update_o  = upd_q;
  assign pend_valid_o  = pend_valid_q;

endmodule
